// File: rtl/moduloaddr_gen.sv
// moduloaddr_gen: modulo / ping-pong address generator for the waveform
// sample-table read path. Programmable limit (modulus = limit+1), step,
// direction, wrap or bounce mode, synchronous preload and a one-cycle
// wrap/turn pulse. Address and pulse are registered.
// Optional build macro MODADDR_FRAC_EN adds a fractional step accumulator
// (parameter FRAC_W, input i_frac_step) whose carry adds one to the step.
module moduloaddr_gen #(
  parameter int ADDR_W = 12,
  parameter int STEP_W = 8
`ifdef MODADDR_FRAC_EN
  ,
  parameter int FRAC_W = 8
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_up,
  input  logic              i_dir,
  input  logic              i_mode,
  input  logic [STEP_W-1:0] i_step,
  input  logic [ADDR_W-1:0] i_limit,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
`ifdef MODADDR_FRAC_EN
  input  logic [FRAC_W-1:0] i_frac_step,
`endif
  output logic [ADDR_W-1:0] o_address,
  output logic              o_wrap
);

  // One extra bit so sums and differences never truncate before the final
  // range decision.
  localparam int XW = ADDR_W + 1;

  typedef enum logic {
    ST_FWD = 1'b0,
    ST_REV = 1'b1
  } state_t;

  logic [ADDR_W-1:0] r_address;
  logic              r_wrap;
  state_t            r_state;
  logic              r_mode_prev;

  logic [XW-1:0]     w_limit_x;
  logic [XW-1:0]     w_mod_x;
  logic [XW-1:0]     w_addr_x;
  logic [XW-1:0]     w_load_x;
  logic [XW-1:0]     w_step_raw;
  logic [XW-1:0]     w_s_cap;
  logic [XW-1:0]     w_s;
  logic [XW-1:0]     w_sum;
  logic              w_carry;
  state_t            w_dir_state;
  state_t            w_cur_state;
  logic [XW-1:0]     w_next_x;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_next_wrap;
  state_t            w_next_state;

`ifdef MODADDR_FRAC_EN
  logic [FRAC_W-1:0] r_frac_acc;
  logic [FRAC_W:0]   w_frac_sum;

  assign w_frac_sum = {1'b0, r_frac_acc} + {1'b0, i_frac_step};
  assign w_carry    = w_frac_sum[FRAC_W];

  // Fractional accumulator: cleared by reset and load, advances with each strobe.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_frac_acc <= {FRAC_W{1'b0}};
    end else if (i_load) begin
      r_frac_acc <= {FRAC_W{1'b0}};
    end else if (i_up) begin
      r_frac_acc <= w_frac_sum[FRAC_W-1:0];
    end else begin
      r_frac_acc <= r_frac_acc;
    end
  end
`else
  assign w_carry = 1'b0;
`endif

  assign w_limit_x  = {1'b0, i_limit};
  assign w_mod_x    = w_limit_x + {{ADDR_W{1'b0}}, 1'b1};
  assign w_addr_x   = {1'b0, r_address};
  assign w_load_x   = {1'b0, i_load_addr};
  assign w_step_raw = {{(XW-STEP_W){1'b0}}, i_step} + {{ADDR_W{1'b0}}, w_carry};

  // Bounce mode may not step past the far end in one move, wrap mode may
  // not step more than one full modulus.
  assign w_s_cap = i_mode ? w_limit_x : w_mod_x;
  assign w_s     = (w_step_raw > w_s_cap) ? w_s_cap : w_step_raw;
  assign w_sum   = w_addr_x + w_s;

  // In wrap mode, and on the first bounce cycle, direction comes from the pin;
  // afterwards the bounce state machine owns it.
  assign w_dir_state = i_dir ? ST_REV : ST_FWD;
  assign w_cur_state = (i_mode && r_mode_prev) ? r_state : w_dir_state;

  // Next address / pulse / bounce state with load > advance > hold priority.
  always_comb begin
    w_next_x     = w_addr_x;
    w_next_wrap  = 1'b0;
    w_next_state = w_cur_state;
    if (i_load) begin
      w_next_x     = (w_load_x > w_limit_x) ? w_limit_x : w_load_x;
      w_next_state = w_dir_state;
    end else if (i_up) begin
      if (w_s == {XW{1'b0}}) begin
        w_next_x = w_addr_x;
      end else if (w_addr_x > w_limit_x) begin
        // Limit was lowered under us: snap to the end we are heading toward.
        w_next_x    = (w_cur_state == ST_REV) ? w_limit_x : {XW{1'b0}};
        w_next_wrap = 1'b1;
      end else begin
        case ({i_mode, (w_cur_state == ST_REV)})
          2'b00: begin
            if (w_sum > w_limit_x) begin
              w_next_x    = w_sum - w_mod_x;
              w_next_wrap = 1'b1;
            end else begin
              w_next_x = w_sum;
            end
          end
          2'b01: begin
            if (w_s > w_addr_x) begin
              w_next_x    = w_addr_x + w_mod_x - w_s;
              w_next_wrap = 1'b1;
            end else begin
              w_next_x = w_addr_x - w_s;
            end
          end
          2'b10: begin
            if (w_sum > w_limit_x) begin
              w_next_x     = (w_limit_x + w_limit_x) - w_sum;
              w_next_state = ST_REV;
              w_next_wrap  = 1'b1;
            end else begin
              w_next_x = w_sum;
            end
          end
          2'b11: begin
            if (w_s > w_addr_x) begin
              w_next_x     = w_s - w_addr_x;
              w_next_state = ST_FWD;
              w_next_wrap  = 1'b1;
            end else begin
              w_next_x = w_addr_x - w_s;
            end
          end
          default: begin
            w_next_x = w_addr_x;
          end
        endcase
      end
    end else begin
      w_next_x = w_addr_x;
    end
  end

  // Results are always within the limit; the guard keeps the register in range
  // should the top bit ever be set.
  assign w_next_addr = w_next_x[ADDR_W] ? i_limit : w_next_x[ADDR_W-1:0];

  // Address, pulse and bounce-state registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_address   <= {ADDR_W{1'b0}};
      r_wrap      <= 1'b0;
      r_state     <= ST_FWD;
      r_mode_prev <= i_mode;
    end else begin
      r_address   <= w_next_addr;
      r_wrap      <= w_next_wrap;
      r_state     <= w_next_state;
      r_mode_prev <= i_mode;
    end
  end

  assign o_address = r_address;
  assign o_wrap    = r_wrap;

endmodule

// File: tb/tb_moduloaddr_gen.sv
// Self-checking bench for moduloaddr_gen: reset checks, a table of directed
// vectors with hand-derived results, and randomized traffic compared with an
// arithmetic reference model (bounce mode modelled as an unfolded ring).
module tb_moduloaddr_gen;

  localparam int ADDR_W = 12;
  localparam int STEP_W = 8;
`ifdef MODADDR_FRAC_EN
  localparam int FRAC_W = 8;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              up;
  logic              dir;
  logic              mode;
  logic [STEP_W-1:0] step;
  logic [ADDR_W-1:0] limit;
  logic              load;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        frac_step;
  logic [ADDR_W-1:0] address;
  logic              wrap;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int m_addr = 0;
  bit m_rev = 1'b0;
  bit m_prev_mode = 1'b0;
  bit m_wrap = 1'b0;
  int m_acc = 0;

  typedef struct {
    logic        rst;
    logic        load;
    logic        up;
    logic        mode;
    logic        dir;
    int          limit;
    int          step;
    int          load_addr;
    int          exp_addr;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[$];

  moduloaddr_gen #(.ADDR_W(ADDR_W), .STEP_W(STEP_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_up        (up),
    .i_dir       (dir),
    .i_mode      (mode),
    .i_step      (step),
    .i_limit     (limit),
    .i_load      (load),
    .i_load_addr (load_addr),
`ifdef MODADDR_FRAC_EN
    .i_frac_step (frac_step),
`endif
    .o_address   (address),
    .o_wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic ld, input logic u,
                              input logic md, input logic dr, input int lim,
                              input int st, input int la, input int ea,
                              input logic ew);
    vec_t v;
    v.rst = r; v.load = ld; v.up = u; v.mode = md; v.dir = dr;
    v.limit = lim; v.step = st; v.load_addr = la;
    v.exp_addr = ea; v.exp_wrap = ew;
    return v;
  endfunction

  // Reference model: one clock edge using the currently driven inputs.
  task automatic model_edge();
    int lim, cap, s, carry, p, span;
    bit rev_now;
    lim = int'(limit);
    rev_now = (mode && m_prev_mode) ? m_rev : dir;
    m_wrap = 1'b0;
    if (!rst) begin
      m_addr = 0; m_rev = 1'b0; m_acc = 0;
    end else if (load) begin
      m_addr = (int'(load_addr) > lim) ? lim : int'(load_addr);
      m_rev = dir; m_acc = 0;
    end else begin
      m_rev = rev_now;
      if (up) begin
        carry = 0;
`ifdef MODADDR_FRAC_EN
        m_acc = m_acc + int'(frac_step);
        if (m_acc >= (1 << FRAC_W)) begin
          m_acc = m_acc - (1 << FRAC_W);
          carry = 1;
        end
`endif
        cap = mode ? lim : lim + 1;
        s = int'(step) + carry;
        if (s > cap) s = cap;
        if (s == 0) begin
          m_wrap = 1'b0;
        end else if (m_addr > lim) begin
          m_addr = rev_now ? lim : 0;
          m_wrap = 1'b1;
        end else if (!mode) begin
          if (!rev_now) begin
            m_wrap = (m_addr + s > lim);
            m_addr = (m_addr + s) % (lim + 1);
          end else begin
            m_wrap = (s > m_addr);
            m_addr = (m_addr - s + lim + 1) % (lim + 1);
          end
        end else begin
          // forward leg covers positions 0..L, return leg L..2L
          span = 2 * lim;
          p = rev_now ? span - m_addr : m_addr;
          p = p + s;
          if (!rev_now && p > lim) begin
            m_wrap = 1'b1; m_rev = 1'b1;
          end else if (rev_now && p > span) begin
            m_wrap = 1'b1; m_rev = 1'b0; p = p - span;
          end
          m_addr = (p > lim) ? span - p : p;
        end
      end
    end
    m_prev_mode = mode;
  endtask

  task automatic edge_check(input string name, input int ea, input int ew);
    @(posedge clk);
    model_edge();
    #1;
    check({name, " addr"}, int'(address), ea);
    check({name, " wrap"}, int'(wrap), ew);
  endtask

  initial begin
    rst = 1'b0; up = 1'b0; dir = 1'b0; mode = 1'b0; step = 8'd4;
    limit = 12'd9; load = 1'b1; load_addr = 12'd5; frac_step = 8'd0;

    // reset dominates load and up
    for (int i = 0; i < 3; i++) begin
      up = (i % 2 == 0);
      edge_check($sformatf("reset%0d", i), 0, 0);
      #1;
    end
    rst = 1'b1; up = 1'b0; load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      edge_check($sformatf("idle%0d", i), 0, 0);
      #1;
    end

    // rst load up mode dir limit step load_addr -> addr wrap
    vecs.push_back(mk(1,0,1,0,0, 9,  4, 0,  4,0));
    vecs.push_back(mk(1,0,1,0,0, 9,  4, 0,  8,0));
    vecs.push_back(mk(1,0,1,0,0, 9,  4, 0,  2,1));
    vecs.push_back(mk(1,0,1,0,0, 9,  4, 0,  6,0));
    vecs.push_back(mk(1,0,1,0,0, 9,  4, 0,  0,1));
    vecs.push_back(mk(1,1,0,0,1, 9,  3, 1,  1,0));
    vecs.push_back(mk(1,0,1,0,1, 9,  3, 0,  8,1));
    vecs.push_back(mk(1,0,1,0,1, 9,  3, 0,  5,0));
    vecs.push_back(mk(1,0,1,0,1, 9,  3, 0,  2,0));
    vecs.push_back(mk(1,0,1,0,1, 9,  3, 0,  9,1));
    vecs.push_back(mk(1,1,0,1,0, 7,  3, 0,  0,0));
    vecs.push_back(mk(1,0,1,1,0, 7,  3, 0,  3,0));
    vecs.push_back(mk(1,0,1,1,0, 7,  3, 0,  6,0));
    vecs.push_back(mk(1,0,1,1,0, 7,  3, 0,  5,1));
    vecs.push_back(mk(1,0,1,1,0, 7,  3, 0,  2,0));
    vecs.push_back(mk(1,0,1,1,0, 7,  3, 0,  1,1));
    vecs.push_back(mk(1,0,1,1,0, 7,  3, 0,  4,0));
    vecs.push_back(mk(1,0,1,1,0, 7,  3, 0,  7,0));
    vecs.push_back(mk(1,0,1,1,0, 7,  3, 0,  4,1));
    vecs.push_back(mk(1,0,0,1,0, 7,  3, 0,  4,0));
    vecs.push_back(mk(1,1,1,0,0, 9,  4, 5,  5,0));
    vecs.push_back(mk(1,1,0,0,0, 9,  4,20,  9,0));
    vecs.push_back(mk(0,1,1,0,0, 9,  4, 5,  0,0));
    vecs.push_back(mk(1,1,0,0,0, 9,  1, 8,  8,0));
    vecs.push_back(mk(1,0,1,0,0, 3,  1, 0,  0,1));
    vecs.push_back(mk(1,1,0,0,1, 9,  1, 8,  8,0));
    vecs.push_back(mk(1,0,1,0,1, 3,  1, 0,  3,1));
    vecs.push_back(mk(1,0,1,0,1, 3,  0, 0,  3,0));
    vecs.push_back(mk(1,0,1,0,0, 0,  5, 0,  0,1));
    vecs.push_back(mk(1,0,1,0,0, 0,  5, 0,  0,1));
    vecs.push_back(mk(1,0,1,0,1, 0,  5, 0,  0,1));
    vecs.push_back(mk(1,1,0,0,1, 9,  3, 3,  3,0));
    vecs.push_back(mk(1,0,1,0,1, 9,  3, 0,  0,0));
    vecs.push_back(mk(1,0,1,0,1, 9,  3, 0,  7,1));
    vecs.push_back(mk(1,1,0,1,0, 7,200, 0,  0,0));
    vecs.push_back(mk(1,0,1,1,0, 7,200, 0,  7,0));
    vecs.push_back(mk(1,0,1,1,0, 7,200, 0,  0,1));
    vecs.push_back(mk(1,0,1,1,0, 7,200, 0,  7,1));
    vecs.push_back(mk(1,1,0,0,0, 4,200, 2,  2,0));
    vecs.push_back(mk(1,0,1,0,0, 4,200, 0,  2,1));
    vecs.push_back(mk(1,0,1,0,0, 4,200, 0,  2,1));
    vecs.push_back(mk(1,0,1,1,1, 4,  1, 0,  1,0));
    vecs.push_back(mk(1,0,1,1,0, 4,  1, 0,  0,0));
    vecs.push_back(mk(1,0,1,1,0, 4,  1, 0,  1,1));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; load = vecs[i].load; up = vecs[i].up;
      mode = vecs[i].mode; dir = vecs[i].dir;
      limit = ADDR_W'(vecs[i].limit); step = STEP_W'(vecs[i].step);
      load_addr = ADDR_W'(vecs[i].load_addr);
      edge_check($sformatf("vec%0d", i), vecs[i].exp_addr, int'(vecs[i].exp_wrap));
      #1;
    end

`ifdef MODADDR_FRAC_EN
    // half-step fraction: 1, 1.5, ... -> 1, 3, 4, 6
    rst = 1'b1; mode = 1'b0; dir = 1'b0; limit = 12'd100; step = 8'd1;
    frac_step = 8'h80; load_addr = 12'd0; load = 1'b1; up = 1'b0;
    edge_check("frac load", 0, 0);
    #1;
    load = 1'b0; up = 1'b1;
    edge_check("frac1", 1, 0); #1;
    edge_check("frac2", 3, 0); #1;
    edge_check("frac3", 4, 0); #1;
    edge_check("frac4", 6, 0); #1;
`endif

    // randomized traffic against the model
    rst = 1'b0; load = 1'b0; up = 1'b0;
    @(posedge clk); model_edge(); #1;
    rst = 1'b1;
    for (int i = 0; i < 800; i++) begin
      rst  = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      load = ($urandom_range(0, 99) < 8);
      up   = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      if ($urandom_range(0, 29) == 0)
        limit = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 4095))
                                            : ADDR_W'($urandom_range(0, 15));
      step = ($urandom_range(0, 7) == 0) ? STEP_W'($urandom_range(0, 255))
                                         : STEP_W'($urandom_range(0, 6));
      load_addr = ADDR_W'($urandom_range(0, int'(limit) + 6));
      frac_step = 8'($urandom_range(0, 255));
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("rand%0d addr", i), int'(address), m_addr);
      check($sformatf("rand%0d wrap", i), int'(wrap), int'(m_wrap));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/moduloaddr_gen.md
Name: moduloaddr_gen

Overview:
- Parametrised modulo address generator for the waveform generator's sample-table read path; successor to the fixed 12-bit up-counter address block.
- Adds programmable modulus (limit), programmable step, up/down direction, wrap or bounce (ping-pong) mode, synchronous preload and a wrap/turn pulse.
- Sits between the control/strobe logic and the waveform ROM/RAM address input; output is registered.

Parameters:
- ADDR_W, 12, address width; table holds up to 2^ADDR_W entries.
- STEP_W, 8, width of the step input; must satisfy STEP_W <= ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- up  in  1  advance strobe; one advance per clock sampled high (held high = advance every cycle).
- dir  in  1  0 = forward (increment), 1 = reverse (decrement).
- mode  in  1  0 = wrap (modulo), 1 = bounce (ping-pong).
- step  in  STEP_W  address increment per advance.
- limit  in  ADDR_W  last valid address; modulus = limit+1.
- load  in  1  synchronous preload of load_addr.
- load_addr  in  ADDR_W  preload value.
- address  out  ADDR_W  current table address, registered.
- wrap  out  1  one-cycle pulse on wrap-around (mode 0) or direction turn (mode 1).

Behaviour:
- Reset (rst=0 at clock edge): address=0, wrap=0, internal bounce state = FWD. Reset overrides load and up.
- Priority per edge: reset > load > up > hold.
- Latency: address and wrap update on the same edge where up/load is sampled; visible 1 cycle after the strobe is applied.
- Load: address <= min(load_addr, limit); bounce state <= dir; wrap <= 0.
- Arithmetic in ADDR_W+1 bits; no intermediate truncation.
- Effective step S: mode 0: min(step, limit+1); mode 1: min(step, limit). step=0 -> address holds, no wrap pulse.
- Mode 0, forward: t = address + S; if t > limit then address <= t - (limit+1), wrap <= 1; else address <= t.
- Mode 0, reverse: if S > address then address <= address + (limit+1) - S, wrap <= 1; else address <= address - S.
- Mode 0: bounce state tracks dir every cycle.
- Mode 1 state machine: states FWD and REV; dir is ignored except on load and on the 0->1 mode transition, where the state is taken from dir.
  - FWD: t = address + S; if t > limit then address <= 2*limit - t, state <= REV, wrap <= 1; else address <= t. Reaching exactly limit does not turn.
  - REV: if S > address then address <= S - address, state <= FWD, wrap <= 1; else address <= address - S. Reaching exactly 0 does not turn.
- limit = 0: address stays 0; wrap pulses on every advance with S > 0.
- Out-of-range (address > limit after limit is reduced): next advance forces address <= 0 (forward/FWD) or limit (reverse/REV), wrap <= 1; step is not applied on that advance.
- wrap is 0 on every cycle without a qualifying event; never high for two cycles unless two consecutive advances each wrap.

Optional Feature:
- Macro MODADDR_FRAC_EN.
- Defined: adds parameter FRAC_W (default 8), input frac_step[FRAC_W-1:0] and an internal FRAC_W-bit fractional accumulator.
  - Each advance adds frac_step to the accumulator; its carry-out adds 1 to S for that advance (before clamping).
  - Accumulator clears on reset and on load.
- Undefined: no frac_step port, no accumulator; integer step only.

Test Plan:
- Reset: rst=0 for 3 cycles while up toggles and load=1 -> address=0, wrap=0 throughout; after rst=1 with no up, address holds 0.
- Wrap forward: mode=0, dir=0, limit=9, step=4, up held high from address 0 -> address 4, 8, 2 (wrap=1), 6, 0 (wrap=1).
- Wrap reverse: mode=0, dir=1, limit=9, step=3, load 1 then up -> address 8 (wrap=1), 5, 2, 9 (wrap=1).
- Bounce: mode=1, dir=0, limit=7, step=3 from 0 -> address 3, 6, 5 (wrap=1, REV), 2, 1 (wrap=1, FWD), 4, 7 (no pulse), 4 (wrap=1).
- Priority and clamp:
  - load=1, up=1, load_addr=5 -> address=5, wrap=0.
  - load_addr=20 with limit=9 -> address=9.
  - rst=0 with load=1 -> address=0.
- Limit reduction: address=8, limit changed to 3, mode=0, dir=0, single up -> address=0, wrap=1. With MODADDR_FRAC_EN: step=1, frac_step=0x80, from 0 -> address 1, 3, 4, 6.
